// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse types, element limits and table entry helper
package morse_pkg;

  localparam int MAX_ELEMS = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MARK,
    ELEM_GAP,
    CHAR_GAP,
    WORD_GAP
  } morse_state_t;

  typedef enum logic [1:0] {
    SYMBOL,
    SPACE,
    INVALID
  } morse_kind_t;

  // pattern is left-aligned: bit MAX_ELEMS-1 is the first element, 1 = dash
  typedef struct packed {
    logic [2:0]           len;
    logic [MAX_ELEMS-1:0] pattern;
    morse_kind_t          kind;
  } morse_code_t;

  function automatic morse_code_t sym(input logic [2:0] len, input logic [MAX_ELEMS-1:0] pat);
    morse_code_t c;
    c.len     = len;
    c.pattern = pat;
    c.kind    = SYMBOL;
    return c;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// rtl/morse_lut.sv - combinational ASCII to Morse code lookup
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0]  ascii_i,
  output morse_code_t code_o
);

  logic [7:0] up;

  // fold lowercase onto uppercase, then look up the element pattern
  always_comb begin
    up = ascii_i;
    if (ascii_i >= 8'h61 && ascii_i <= 8'h7a) up = ascii_i - 8'h20;
    code_o.len     = 3'd0;
    code_o.pattern = '0;
    code_o.kind    = INVALID;
    case (up)
      8'h20: code_o.kind = SPACE;
      "A": code_o = sym(3'd2, 5'b01000);
      "B": code_o = sym(3'd4, 5'b10000);
      "C": code_o = sym(3'd4, 5'b10100);
      "D": code_o = sym(3'd3, 5'b10000);
      "E": code_o = sym(3'd1, 5'b00000);
      "F": code_o = sym(3'd4, 5'b00100);
      "G": code_o = sym(3'd3, 5'b11000);
      "H": code_o = sym(3'd4, 5'b00000);
      "I": code_o = sym(3'd2, 5'b00000);
      "J": code_o = sym(3'd4, 5'b01110);
      "K": code_o = sym(3'd3, 5'b10100);
      "L": code_o = sym(3'd4, 5'b01000);
      "M": code_o = sym(3'd2, 5'b11000);
      "N": code_o = sym(3'd2, 5'b10000);
      "O": code_o = sym(3'd3, 5'b11100);
      "P": code_o = sym(3'd4, 5'b01100);
      "Q": code_o = sym(3'd4, 5'b11010);
      "R": code_o = sym(3'd3, 5'b01000);
      "S": code_o = sym(3'd3, 5'b00000);
      "T": code_o = sym(3'd1, 5'b10000);
      "U": code_o = sym(3'd3, 5'b00100);
      "V": code_o = sym(3'd4, 5'b00010);
      "W": code_o = sym(3'd3, 5'b01100);
      "X": code_o = sym(3'd4, 5'b10010);
      "Y": code_o = sym(3'd4, 5'b10110);
      "Z": code_o = sym(3'd4, 5'b11000);
      "0": code_o = sym(3'd5, 5'b11111);
      "1": code_o = sym(3'd5, 5'b01111);
      "2": code_o = sym(3'd5, 5'b00111);
      "3": code_o = sym(3'd5, 5'b00011);
      "4": code_o = sym(3'd5, 5'b00001);
      "5": code_o = sym(3'd5, 5'b00000);
      "6": code_o = sym(3'd5, 5'b10000);
      "7": code_o = sym(3'd5, 5'b11000);
      "8": code_o = sym(3'd5, 5'b11100);
      "9": code_o = sym(3'd5, 5'b11110);
      default: ;
    endcase
  end

endmodule

// File: rtl/morse_tx_param.sv
// rtl/morse_tx_param.sv - buffered, parametrised Morse keyer with handshake input
module morse_tx_param
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES    = 4,
  parameter int DASH_UNITS     = 3,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_data_morse,
  output logic       o_busy,
  output logic       o_err
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int WG_UNITS = WORD_GAP_UNITS - CHAR_GAP_UNITS;
  localparam int MAXU     = (DASH_UNITS > WORD_GAP_UNITS) ? DASH_UNITS : WORD_GAP_UNITS;
  localparam int UW       = (MAXU > 1) ? $clog2(MAXU) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // character buffer
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop, fifo_empty;

  // keyer state
  morse_state_t         state_q, state_d;
  logic [CW-1:0]        cyc_q;
  logic [UW-1:0]        units_q;
  logic [UW-1:0]        tgt_last;
  logic                 tmr_done;
  logic [2:0]           len_q;
  logic [MAX_ELEMS-1:0] pat_q;
  logic [2:0]           idx_q;
  logic                 last_elem;
  logic                 err_q;
  morse_code_t          code;

  assign fifo_empty = (count_q == '0);
  assign push       = i_valid && (count_q != FULL_CNT);
  assign pop        = (state_q == LOAD);

  morse_lut u_lut (
    .ascii_i (mem_q[rd_ptr_q]),
    .code_o  (code)
  );

  // buffer storage, written on each accepted handshake
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  // buffer pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // last unit index of the timed interval for the current state
  always_comb begin
    tgt_last = '0;
    case (state_q)
      MARK:     tgt_last = pat_q[MAX_ELEMS-1] ? UW'(DASH_UNITS - 1) : '0;
      CHAR_GAP: tgt_last = UW'(CHAR_GAP_UNITS - 1);
      WORD_GAP: tgt_last = UW'(WG_UNITS - 1);
      default:  tgt_last = '0;
    endcase
  end

  assign tmr_done  = (cyc_q == CYC_LAST) && (units_q == tgt_last);
  assign last_elem = (idx_q == len_q - 3'd1);

  // state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        case (code.kind)
          SYMBOL:  state_d = MARK;
          SPACE:   state_d = WORD_GAP;
          default: state_d = IDLE;
        endcase
      end
      MARK:     if (tmr_done) state_d = last_elem ? CHAR_GAP : ELEM_GAP;
      ELEM_GAP: if (tmr_done) state_d = MARK;
      CHAR_GAP: if (tmr_done) state_d = IDLE;
      WORD_GAP: if (tmr_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    o_data_morse = (state_q == MARK);
    o_busy       = !fifo_empty || (state_q != IDLE);
    o_ready      = (count_q != FULL_CNT);
    o_err        = err_q;
  end

  // cycle/unit timer, restarted on every state entry and saturating at its terminal count
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cyc_q   <= '0;
      units_q <= '0;
    end else if (state_d != state_q) begin
      cyc_q   <= '0;
      units_q <= '0;
    end else if (state_q inside {MARK, ELEM_GAP, CHAR_GAP, WORD_GAP}) begin
      if (cyc_q == CYC_LAST) begin
        cyc_q <= '0;
        if (units_q != tgt_last) units_q <= units_q + UW'(1);
      end else begin
        cyc_q <= cyc_q + CW'(1);
      end
    end
  end

  // character latch, element walk and error pulse
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      len_q <= '0;
      pat_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == LOAD) && (code.kind == INVALID);
      if (state_q == LOAD) begin
        len_q <= code.len;
        pat_q <= code.pattern;
        idx_q <= '0;
      end else if (state_q == MARK && tmr_done) begin
        idx_q <= idx_q + 3'd1;
        pat_q <= {pat_q[MAX_ELEMS-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_morse_tx_param.sv
// tb/tb_morse_tx_param.sv - directed self-checking bench for morse_tx_param
module tb_morse_tx_param;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready, o_data_morse, o_busy, o_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int   rise_q[$];
  int   fall_q[$];
  int   err_cyc_q[$];
  int   busy_fall = -1;
  logic line_prev = 1'b0;
  logic busy_prev = 1'b0;

  morse_tx_param #(
    .UNIT_CYCLES    (4),
    .DASH_UNITS     (3),
    .CHAR_GAP_UNITS (3),
    .WORD_GAP_UNITS (7),
    .FIFO_DEPTH     (4)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_data_morse (o_data_morse),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc = cyc + 1;

  always @(negedge i_clk) begin
    if (o_data_morse && !line_prev) rise_q.push_back(cyc);
    if (!o_data_morse && line_prev) fall_q.push_back(cyc);
    if (!o_busy && busy_prev) busy_fall = cyc;
    if (o_err) err_cyc_q.push_back(cyc);
    line_prev = o_data_morse;
    busy_prev = o_busy;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_mon();
    rise_q.delete();
    fall_q.delete();
    err_cyc_q.delete();
    busy_fall = -1;
  endtask

  task automatic send(input logic [7:0] c, output int h, output int stalls);
    logic rdy;
    bit   done;
    stalls = 0;
    done   = 0;
    h      = -1;
    i_data  = c;
    i_valid = 1'b1;
    for (int n = 0; n < 1000 && !done; n++) begin
      rdy = o_ready;
      tick();
      if (rdy) begin
        h    = cyc;
        done = 1;
      end else begin
        stalls++;
      end
    end
    i_valid = 1'b0;
    if (!done) check("send handshake timeout", 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 2000) begin
      tick();
      n++;
    end
    check({tag, " reaches idle"}, o_busy, 0);
    tick();
    tick();
  endtask

  task automatic wait_rise();
    int n;
    n = 0;
    while (rise_q.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    check("mark start seen", int'(rise_q.size() > 0), 1);
  endtask

  int h, st, sum_st, h2;
  int exp_mark[8] = '{12, 4, 4, 12, 12, 4, 4, 4};
  int exp_gap[7]  = '{14, 14, 4, 14, 4, 14, 4};

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check("reset line", o_data_morse, 0);
    check("reset busy", o_busy, 0);
    check("reset err", o_err, 0);
    i_rst = 1'b1;
    tick();
    check("post-reset ready", o_ready, 1);
    check("post-reset busy", o_busy, 0);

    // single 'E'
    clear_mon();
    send(8'h45, h, st);
    wait_idle("E");
    check("E mark count", rise_q.size(), 1);
    if (rise_q.size() == 1 && fall_q.size() == 1) begin
      check("E latency", rise_q[0] - h, 2);
      check("E mark len", fall_q[0] - rise_q[0], 4);
      check("E busy fall after gap", busy_fall - fall_q[0], 12);
    end

    // lowercase 'a' keyed as 'A'
    clear_mon();
    send(8'h61, h, st);
    wait_idle("a");
    check("a mark count", rise_q.size(), 2);
    if (rise_q.size() == 2 && fall_q.size() == 2) begin
      check("a latency", rise_q[0] - h, 2);
      check("a dot", fall_q[0] - rise_q[0], 4);
      check("a elem gap", rise_q[1] - fall_q[0], 4);
      check("a dash", fall_q[1] - rise_q[1], 12);
      check("a busy fall after gap", busy_fall - fall_q[1], 12);
    end

    // "E E" with a word gap
    clear_mon();
    send(8'h45, h, st);
    send(8'h20, h2, st);
    send(8'h45, h2, st);
    wait_idle("E E");
    check("E E mark count", rise_q.size(), 2);
    if (rise_q.size() == 2 && fall_q.size() == 2) begin
      check("E E first mark", fall_q[0] - rise_q[0], 4);
      check("E E word low", rise_q[1] - fall_q[0], 32);
      check("E E second mark", fall_q[1] - rise_q[1], 4);
    end

    // "TEANI": fill the buffer while 'T' is keyed
    clear_mon();
    send("T", h, st);
    wait_rise();
    sum_st = 0;
    send("E", h2, st); sum_st += st;
    send("A", h2, st); sum_st += st;
    send("N", h2, st); sum_st += st;
    send("I", h2, st); sum_st += st;
    check("fill without stall", sum_st, 0);
    check("ready low when full", o_ready, 0);
    i_data  = 8'h45;
    i_valid = 1'b1;
    repeat (3) tick();
    i_valid = 1'b0;
    check("ready still low", o_ready, 0);
    wait_idle("TEANI");
    check("TEANI mark count", rise_q.size(), 8);
    check("TEANI fall count", fall_q.size(), 8);
    if (rise_q.size() == 8 && fall_q.size() == 8) begin
      for (int i = 0; i < 8; i++) check($sformatf("TEANI mark %0d", i), fall_q[i] - rise_q[i], exp_mark[i]);
      for (int i = 0; i < 7; i++) check($sformatf("TEANI gap %0d", i), rise_q[i+1] - fall_q[i], exp_gap[i]);
    end

    // unsupported '#', then 'T'
    clear_mon();
    send(8'h23, h, st);
    wait_idle("#");
    check("# err pulses", err_cyc_q.size(), 1);
    if (err_cyc_q.size() == 1) check("# err timing", err_cyc_q[0] - h, 2);
    check("# no marks", rise_q.size(), 0);
    clear_mon();
    send("T", h, st);
    wait_idle("T after #");
    check("T mark count", rise_q.size(), 1);
    if (rise_q.size() == 1 && fall_q.size() == 1) begin
      check("T latency", rise_q[0] - h, 2);
      check("T dash", fall_q[0] - rise_q[0], 12);
    end
    check("T no err", err_cyc_q.size(), 0);

    // reset in the middle of a dash with a character still buffered
    clear_mon();
    send("T", h, st);
    send("E", h2, st);
    wait_rise();
    repeat (5) tick();
    check("line high before reset", o_data_morse, 1);
    i_rst = 1'b0;
    #1;
    check("reset drops line", o_data_morse, 0);
    check("reset drops busy", o_busy, 0);
    tick();
    i_rst = 1'b1;
    tick();
    clear_mon();
    repeat (60) tick();
    check("no residual marks", rise_q.size(), 0);
    check("idle after reset", o_busy, 0);
    check("ready after reset", o_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
